// File: rtl/stack_link_ctrl.sv
// stack_link_ctrl: sequences SP/LR/PC register-file writes for CALL, RET, PUSH_LR, POP_LR.
// Latency: CALL/RET 1 cycle from accept; PUSH/POP 1 cycle after the memory ack edge.
// Backpressure: op_ready is high only in IDLE, and memory stalls are held until mem_ack.
// Optional macro STACK_LINK_GUARD_EN adds stack overflow/underflow fault checks.
module stack_link_ctrl #(
  parameter logic [31:0] PC_STEP     = 32'd4
`ifdef STACK_LINK_GUARD_EN
  ,
  parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_target,
  input  logic [31:0] cur_sp,
  input  logic [31:0] cur_lr,
  input  logic [31:0] cur_pc,
  output logic        wr_sp,
  output logic [31:0] wr_sp_data,
  output logic        wr_lr,
  output logic [31:0] wr_lr_data,
  output logic        wr_pc,
  output logic [31:0] wr_pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        op_done,
  output logic        op_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  state_t      state, nx_state;
  logic [1:0]  op_q, nx_op;
  logic [31:0] sp_q, nx_sp;

  logic        nx_op_ready, nx_op_done, nx_op_fault;
  logic        nx_wr_sp, nx_wr_lr, nx_wr_pc;
  logic [31:0] nx_wr_sp_data, nx_wr_lr_data, nx_wr_pc_data;
  logic        nx_mem_req, nx_mem_we;
  logic [31:0] nx_mem_addr, nx_mem_wdata;

  logic        guard_fault;
  logic        accept;

  assign accept = op_valid && op_ready;

`ifdef STACK_LINK_GUARD_EN
  // Guard: a push below the limit overflows, a pop from an empty stack underflows.
  always_comb begin
    guard_fault = 1'b0;
    if (op_code == OP_PUSH)
      guard_fault = (cur_sp - 32'd4) < STACK_LIMIT;
    else if (op_code == OP_POP)
      guard_fault = cur_sp >= STACK_BASE;
  end
`else
  assign guard_fault = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    nx_state      = state;
    nx_op         = op_q;
    nx_sp         = sp_q;
    nx_op_done    = 1'b0;
    nx_op_fault   = 1'b0;
    nx_wr_sp      = 1'b0;
    nx_wr_lr      = 1'b0;
    nx_wr_pc      = 1'b0;
    nx_wr_sp_data = 32'd0;
    nx_wr_lr_data = 32'd0;
    nx_wr_pc_data = 32'd0;
    nx_mem_req    = 1'b0;
    nx_mem_we     = 1'b0;
    nx_mem_addr   = 32'd0;
    nx_mem_wdata  = 32'd0;

    case (state)
      IDLE: begin
        if (accept) begin
          nx_op = op_code;
          nx_sp = cur_sp;
          case (op_code)
            OP_CALL: begin
              nx_state      = DONE;
              nx_op_done    = 1'b1;
              nx_wr_lr      = 1'b1;
              nx_wr_lr_data = cur_pc + PC_STEP;
              nx_wr_pc      = 1'b1;
              nx_wr_pc_data = op_target;
            end
            OP_RET: begin
              nx_state      = DONE;
              nx_op_done    = 1'b1;
              nx_wr_pc      = 1'b1;
              nx_wr_pc_data = cur_lr;
            end
            default: begin
              if (guard_fault) begin
                // Aborted stack op: report completion with fault, touch nothing.
                nx_state    = DONE;
                nx_op_done  = 1'b1;
                nx_op_fault = 1'b1;
              end else begin
                nx_state     = MEM;
                nx_mem_req   = 1'b1;
                nx_mem_we    = (op_code == OP_PUSH);
                nx_mem_addr  = (op_code == OP_PUSH) ? (cur_sp - 32'd4) : cur_sp;
                nx_mem_wdata = (op_code == OP_PUSH) ? cur_lr : 32'd0;
              end
            end
          endcase
        end
      end

      MEM: begin
        if (mem_ack) begin
          nx_state   = DONE;
          nx_op_done = 1'b1;
          nx_wr_sp   = 1'b1;
          if (op_q == OP_POP) begin
            nx_wr_sp_data = sp_q + 32'd4;
            nx_wr_lr      = 1'b1;
            nx_wr_lr_data = mem_rdata;
          end else begin
            nx_wr_sp_data = sp_q - 32'd4;
          end
        end else begin
          // Request stays stable until the memory acknowledges it.
          nx_mem_req   = mem_req;
          nx_mem_we    = mem_we;
          nx_mem_addr  = mem_addr;
          nx_mem_wdata = mem_wdata;
        end
      end

      DONE: nx_state = IDLE;

      default: nx_state = IDLE;
    endcase

    nx_op_ready = (nx_state == IDLE);
  end

  // State and registered outputs; reset aborts any op in flight without side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_CALL;
      sp_q       <= 32'd0;
      op_ready   <= 1'b1;
      op_done    <= 1'b0;
      op_fault   <= 1'b0;
      wr_sp      <= 1'b0;
      wr_lr      <= 1'b0;
      wr_pc      <= 1'b0;
      wr_sp_data <= 32'd0;
      wr_lr_data <= 32'd0;
      wr_pc_data <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      state      <= nx_state;
      op_q       <= nx_op;
      sp_q       <= nx_sp;
      op_ready   <= nx_op_ready;
      op_done    <= nx_op_done;
      op_fault   <= nx_op_fault;
      wr_sp      <= nx_wr_sp;
      wr_lr      <= nx_wr_lr;
      wr_pc      <= nx_wr_pc;
      wr_sp_data <= nx_wr_sp_data;
      wr_lr_data <= nx_wr_lr_data;
      wr_pc_data <= nx_wr_pc_data;
      mem_req    <= nx_mem_req;
      mem_we     <= nx_mem_we;
      mem_addr   <= nx_mem_addr;
      mem_wdata  <= nx_mem_wdata;
    end
  end

endmodule

// File: tb/tb_stack_link_ctrl.sv
// Directed bench for stack_link_ctrl: CALL/RET, PUSH/POP with ack delays, guard, reset abort.
module tb_stack_link_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_target = 32'd0;
  logic [31:0] cur_sp = 32'd0;
  logic [31:0] cur_lr = 32'd0;
  logic [31:0] cur_pc = 32'd0;
  logic        wr_sp, wr_lr, wr_pc;
  logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        op_done, op_fault;

  int n_tests = 0;
  int n_fail  = 0;

  stack_link_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_target  (op_target),
    .cur_sp     (cur_sp),
    .cur_lr     (cur_lr),
    .cur_pc     (cur_pc),
    .wr_sp      (wr_sp),
    .wr_sp_data (wr_sp_data),
    .wr_lr      (wr_lr),
    .wr_lr_data (wr_lr_data),
    .wr_pc      (wr_pc),
    .wr_pc_data (wr_pc_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .op_done    (op_done),
    .op_fault   (op_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control vector order: {op_ready, mem_req, mem_we, wr_sp, wr_lr, wr_pc, op_done, op_fault}
  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, op_ready, mem_req, mem_we, wr_sp, wr_lr, wr_pc, op_done, op_fault},
        {24'd0, exp});
  endtask

  task automatic chk_idle(input string tag);
    chk_ctl(tag, 8'b1000_0000);
  endtask

  initial begin
    // 1. Asynchronous reset pulsed mid-clock.
    #3 rst = 1'b1;
    #1;
    chk_idle("reset_ctl");
    chk("reset_data", wr_sp_data | wr_lr_data | wr_pc_data | mem_addr | mem_wdata, 32'd0);
    #3 rst = 1'b0;
    tick();
    chk_idle("post_reset_ctl");

    // 2. Back-to-back CALL with op_valid held through the busy cycle, then RET.
    op_valid = 1'b1; op_code = 2'b00; cur_pc = 32'h100; op_target = 32'h240;
    tick();
    chk_ctl("call_done_ctl", 8'b0000_1110);
    chk("call_lr_data", wr_lr_data, 32'h104);
    chk("call_pc_data", wr_pc_data, 32'h240);
    tick();
    chk_ctl("call_gap_ctl", 8'b1000_0000);
    tick();
    chk_ctl("call2_done_ctl", 8'b0000_1110);
    chk("call2_lr_data", wr_lr_data, 32'h104);
    op_valid = 1'b0;
    tick();
    chk_idle("call2_idle");

    op_valid = 1'b1; op_code = 2'b01; cur_lr = 32'h104;
    tick();
    op_valid = 1'b0; cur_lr = 32'h0;
    chk_ctl("ret_done_ctl", 8'b0000_0110);
    chk("ret_pc_data", wr_pc_data, 32'h104);
    tick();
    chk_idle("ret_idle");

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_idle("stray_ack_idle");

    // 3. PUSH_LR with ack three cycles after the request appears.
    op_valid = 1'b1; op_code = 2'b10; cur_sp = 32'h1000; cur_lr = 32'hDEAD_BEEF;
    tick();
    op_valid = 1'b0; cur_sp = 32'h2000; cur_lr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("push_mem_ctl", 8'b0110_0000);
      chk("push_addr", mem_addr, 32'h0000_0FFC);
      chk("push_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk_ctl("push_done_ctl", 8'b0001_0010);
    chk("push_sp_data", wr_sp_data, 32'h0000_0FFC);
    tick();
    chk_idle("push_idle");

    // 4. POP_LR acknowledged in the first memory cycle.
    op_valid = 1'b1; op_code = 2'b11; cur_sp = 32'h0FFC; mem_rdata = 32'h1234_5678;
    tick();
    op_valid = 1'b0;
    chk_ctl("pop_mem_ctl", 8'b0100_0000);
    chk("pop_addr", mem_addr, 32'h0000_0FFC);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk_ctl("pop_done_ctl", 8'b0001_1010);
    chk("pop_lr_data", wr_lr_data, 32'h1234_5678);
    chk("pop_sp_data", wr_sp_data, 32'h0000_1000);
    tick();
    chk_idle("pop_idle");

    // 5. Stack limit behaviour.
`ifdef STACK_LINK_GUARD_EN
    op_valid = 1'b1; op_code = 2'b10; cur_sp = 32'h0800; cur_lr = 32'h55;
    tick();
    op_valid = 1'b0;
    chk_ctl("push_ovf_ctl", 8'b0000_0011);
    tick();
    chk_idle("push_ovf_idle");
    op_valid = 1'b1; op_code = 2'b11; cur_sp = 32'h1000;
    tick();
    op_valid = 1'b0;
    chk_ctl("pop_unf_ctl", 8'b0000_0011);
    tick();
    chk_idle("pop_unf_idle");
`else
    op_valid = 1'b1; op_code = 2'b10; cur_sp = 32'h0800; cur_lr = 32'h55;
    tick();
    op_valid = 1'b0;
    chk_ctl("push_low_ctl", 8'b0110_0000);
    chk("push_low_addr", mem_addr, 32'h0000_07FC);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_ctl("push_low_done", 8'b0001_0010);
    chk("push_low_sp", wr_sp_data, 32'h0000_07FC);
    tick();
    chk_idle("push_low_idle");
`endif

    // 6. Reset while a PUSH waits for its ack.
    op_valid = 1'b1; op_code = 2'b10; cur_sp = 32'h1000; cur_lr = 32'hCAFE_F00D;
    tick();
    op_valid = 1'b0;
    chk_ctl("abort_mem_ctl", 8'b0110_0000);
    tick();
    #2 rst = 1'b1;
    #1;
    chk_idle("abort_async_ctl");
    chk("abort_addr", mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_idle("abort_release_ctl");
    tick();
    chk_idle("abort_no_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_link_ctrl.md
Name: stack_link_ctrl

Overview:
Sequencer that drives the SP, LR and PC write channels of the special register file. It executes four control-flow/stack operations: CALL, RET, PUSH_LR and POP_LR. It reads current SP/LR/PC from the register file's direct read channels. PUSH_LR and POP_LR use a single-word data-memory port with a req/ack handshake.

Parameters:
STACK_BASE, 32'h0000_1000, empty-stack SP value (full-descending stack; SP points at last pushed word)
STACK_LIMIT, 32'h0000_0800, lowest legal pushed-word address
PC_STEP, 32'd4, return-address increment for CALL

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  operation request
op_ready  out  1  high only in IDLE; op accepted on posedge when op_valid&&op_ready
op_code  in  2  00 CALL, 01 RET, 10 PUSH_LR, 11 POP_LR
op_target  in  32  branch target for CALL (ignored otherwise)
cur_sp  in  32  current SP from register file
cur_lr  in  32  current LR from register file
cur_pc  in  32  current PC from register file
wr_sp  out  1  SP write strobe
wr_sp_data  out  32  SP write data
wr_lr  out  1  LR write strobe
wr_lr_data  out  32  LR write data
wr_pc  out  1  PC write strobe
wr_pc_data  out  32  PC write data
mem_req  out  1  memory request
mem_we  out  1  1 = write (PUSH), 0 = read (POP)
mem_addr  out  32  word address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_ack=1
mem_ack  in  1  memory completion, single-cycle pulse
op_done  out  1  one-cycle pulse on completion
op_fault  out  1  valid with op_done; 1 = operation aborted

Behaviour:
- Clocking and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset: state=IDLE, op_ready=1. All strobes, mem_req, mem_we, op_done and op_fault are 0. All data/address outputs are 0.
- States: IDLE, MEM, DONE. All outputs are registered.
- cur_sp, cur_lr and cur_pc are sampled only on the acceptance edge. Later changes do not affect the op in flight.
- IDLE -> DONE on accept of CALL, RET, or a faulting PUSH/POP. IDLE -> MEM on accept of a non-faulting PUSH/POP.
- CALL: DONE drives wr_lr=1 with wr_lr_data=cur_pc+PC_STEP, and wr_pc=1 with wr_pc_data=op_target. Latency is 1 cycle from accept.
- RET: DONE drives wr_pc=1 with wr_pc_data=cur_lr.
- PUSH_LR (MEM state): mem_req=1, mem_we=1, mem_addr=cur_sp-4, mem_wdata=cur_lr.
  - Held stable until the edge where mem_ack=1, then -> DONE.
  - DONE drives wr_sp=1 with wr_sp_data=cur_sp-4.
- POP_LR (MEM state): mem_req=1, mem_we=0, mem_addr=cur_sp.
  - On the ack edge, mem_rdata is captured and the state moves to DONE.
  - DONE drives wr_lr=1 with wr_lr_data=captured data, and wr_sp=1 with wr_sp_data=cur_sp+4.
- mem_req drops in the same cycle the state leaves MEM. mem_ack outside MEM is ignored.
- DONE lasts exactly one cycle: op_done=1 and strobes are high for that cycle only, then -> IDLE.
  - Minimum op-to-op spacing is 2 cycles for CALL/RET and 3+ cycles for PUSH/POP.
- Arithmetic is 32-bit modulo with no carry out. SP alignment is not checked.
- Faults (see STACK_LINK_GUARD_EN): op_fault=1 with op_done=1, no write strobes, no mem_req.
- Reset mid-operation: returns to IDLE immediately. mem_req deasserts asynchronously. No strobes or op_done are issued for the aborted op.
- op_valid while not ready: the request is held off, not dropped. The requester must keep op_valid and operands stable.

Optional Feature:
STACK_LINK_GUARD_EN
- Defined:
  - PUSH_LR with (cur_sp-4) < STACK_LIMIT, unsigned, faults as overflow.
  - POP_LR with cur_sp >= STACK_BASE, unsigned, faults as underflow.
- Undefined: the guard logic is absent, op_fault is tied 0, and all PUSH/POP ops reach memory.

Test Plan:
1. Reset with rst pulsed mid-clock (asynchronous) -> op_ready=1, all strobes/mem_req/op_done=0, all data outputs=0.
2. CALL with cur_pc=0x100, op_target=0x240 -> 1 cycle later: wr_lr=1 with data 0x104, wr_pc=1 with data 0x240, op_done=1 for one cycle. Then RET with cur_lr=0x104 -> wr_pc=1 with data 0x104.
3. PUSH_LR with cur_sp=0x1000, cur_lr=0xDEAD_BEEF, mem_ack delayed 3 cycles -> mem_req/we=1, addr=0xFFC, wdata=0xDEADBEEF held 3 cycles. Next cycle: wr_sp=1 with data 0xFFC, op_done=1, op_fault=0.
4. POP_LR with cur_sp=0xFFC, mem_rdata=0x1234_5678 with same-cycle ack -> mem_we=0, addr=0xFFC. Then wr_lr=1 with data 0x12345678, wr_sp=1 with data 0x1000.
5. With STACK_LINK_GUARD_EN defined:
   - PUSH_LR at cur_sp=0x800 -> op_done=1, op_fault=1, no mem_req, no strobes.
   - POP_LR at cur_sp=0x1000 -> same response.
   Without the macro, the same PUSH issues mem_req at address 0x7FC.
6. PUSH_LR in progress with mem_ack held 0; assert rst -> mem_req drops immediately, no wr_sp, no op_done. After release, op_ready=1.
